// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload channel between pipeline stages.
// The producer drives valid/data; the consumer drives ready.
interface pipe_stage_skid_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with optional one-entry skid and a saturating stall counter.
// The input-to-output latency is 1 cycle. With SKID=1, ready is a register output and 2 entries absorb a stall; with SKID=0, ready follows the downstream ready.
module pipe_stage_skid #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1,
  parameter int               CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_skid_if.slave      up,
  pipe_stage_skid_if.master     down,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             load;
  logic             ready;
  logic             accept;

  assign load = !main_valid || down.ready;

  generate
    if (SKID) begin : g_skid
      // Only depends on local state, so no combinational path from downstream ready.
      assign ready = !skid_valid && !flush;
    end else begin : g_noskid
      assign ready = load && !flush;
    end
  endgenerate

  assign accept     = up.valid && ready;
  assign up.ready   = ready;
  assign down.valid = main_valid;
  assign down.data  = main_data;

  // The main register holds BUBBLE whenever it is empty, so out_data needs no output mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE;
      skid_valid <= 1'b0;
    end else if (load) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= up.valid;
        main_data  <= up.valid ? up.data : BUBBLE;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= up.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !down.ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vectors, corner sequences and a queue-model scoreboard.
module tb_pipe_stage_skid;

  localparam logic [31:0] BUB = 32'hDEAD0013;

  logic        clk;
  logic        rst;
  logic        flush_s;
  logic        flush_n;
  logic [3:0]  stall_s;
  logic [15:0] stall_n;

  int tests = 0;
  int fails = 0;

  pipe_stage_skid_if #(.WIDTH(32)) up_s ();
  pipe_stage_skid_if #(.WIDTH(32)) dn_s ();
  pipe_stage_skid_if #(.WIDTH(32)) up_n ();
  pipe_stage_skid_if #(.WIDTH(32)) dn_n ();

  pipe_stage_skid #(.WIDTH(32), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush_s), .up(up_s), .down(dn_s), .stall_cnt(stall_s)
  );

  pipe_stage_skid #(.WIDTH(32), .BUBBLE(BUB), .SKID(1'b0), .CNT_W(16)) dut_n (
    .clk(clk), .rst(rst), .flush(flush_n), .up(up_n), .down(dn_n), .stall_cnt(stall_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    up_s.valid = 1'b0; up_s.data = '0; dn_s.ready = 1'b0; flush_s = 1'b0;
    up_n.valid = 1'b0; up_n.data = '0; dn_n.ready = 1'b0; flush_n = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        exp_ird;
    logic        exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  vec_t vecs[$];

  // Model: an ordered queue of live entries (capacity 2 with skid, 1 without).
  logic [31:0] q_s[$];
  logic [31:0] q_n[$];
  int          cnt_s;
  int          cnt_n;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset state
    do_reset();
    #1;
    chk("reset out_valid", {31'd0, dn_s.valid}, 32'd0);
    chk("reset out_data", dn_s.data, BUB);
    chk("reset stall_cnt", {28'd0, stall_s}, 32'd0);
    chk("reset in_ready", {31'd0, up_s.ready}, 32'd1);
    chk("reset noskid in_ready", {31'd0, up_n.ready}, 32'd1);

    //             iv    data    ordy  fl    ird   ov    od
    vecs.push_back('{1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1});
    vecs.push_back('{1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b1, 32'h2});
    vecs.push_back('{1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h3});
    vecs.push_back('{1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4});
    vecs.push_back('{1'b1, 32'hA,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA});
    vecs.push_back('{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA});
    vecs.push_back('{1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA});
    vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hB});
    vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, BUB});
    vecs.push_back('{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11});
    vecs.push_back('{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11});
    vecs.push_back('{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, BUB});
    vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, BUB});
    vecs.push_back('{1'b1, 32'h5,  1'b1, 1'b0, 1'b1, 1'b1, 32'h5});
    vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, BUB});

    foreach (vecs[i]) begin
      up_s.valid = vecs[i].iv;
      up_s.data  = vecs[i].id;
      dn_s.ready = vecs[i].ordy;
      flush_s    = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d in_ready", i), {31'd0, up_s.ready}, {31'd0, vecs[i].exp_ird});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), {31'd0, dn_s.valid}, {31'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d out_data", i), dn_s.data, vecs[i].exp_od);
      @(negedge clk);
    end
    chk("table stall_cnt", {28'd0, stall_s}, 32'd4);
    idle_inputs();

    // Saturation at CNT_W=4, then flush does not clear the counter
    do_reset();
    up_s.valid = 1'b1; up_s.data = 32'h77; dn_s.ready = 1'b0;
    @(negedge clk);
    up_s.valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("sat stall_cnt", {28'd0, stall_s}, 32'd15);
    chk("sat out_data held", dn_s.data, 32'h77);
    repeat (3) @(negedge clk);
    #1;
    chk("sat stall_cnt held", {28'd0, stall_s}, 32'd15);
    flush_s = 1'b1;
    @(negedge clk);
    flush_s = 1'b0;
    #1;
    chk("flush keeps stall_cnt", {28'd0, stall_s}, 32'd15);
    chk("flush out_valid", {31'd0, dn_s.valid}, 32'd0);

    // Reset while holding an entry, with flush asserted too
    up_s.valid = 1'b1; up_s.data = 32'h99;
    @(negedge clk);
    up_s.valid = 1'b0;
    #1;
    chk("pre-reset out_valid", {31'd0, dn_s.valid}, 32'd1);
    rst = 1'b1; flush_s = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush_s = 1'b0;
    #1;
    chk("rst+flush out_valid", {31'd0, dn_s.valid}, 32'd0);
    chk("rst+flush out_data", dn_s.data, BUB);
    chk("rst+flush stall_cnt", {28'd0, stall_s}, 32'd0);
    chk("rst+flush in_ready", {31'd0, up_s.ready}, 32'd1);

    // SKID=0: ready drops in the same cycle as out_ready
    do_reset();
    up_n.valid = 1'b1; up_n.data = 32'h33; dn_n.ready = 1'b1;
    #1;
    chk("noskid ird idle", {31'd0, up_n.ready}, 32'd1);
    @(negedge clk);
    up_n.data = 32'h44; dn_n.ready = 1'b0;
    #1;
    chk("noskid ird comb", {31'd0, up_n.ready}, 32'd0);
    chk("noskid out_data", dn_n.data, 32'h33);
    @(negedge clk);
    #1;
    chk("noskid out_data held", dn_n.data, 32'h33);
    dn_n.ready = 1'b1;
    #1;
    chk("noskid ird release", {31'd0, up_n.ready}, 32'd1);
    @(negedge clk);
    up_n.valid = 1'b0;
    #1;
    chk("noskid next word", dn_n.data, 32'h44);
    chk("noskid stall_cnt", {16'd0, stall_n}, 32'd1);

    // Random traffic on both variants against the queue model
    do_reset();
    q_s.delete(); q_n.delete();
    cnt_s = 0; cnt_n = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic iv_s, or_s, fl_s, ird_s;
      logic iv_n, or_n, fl_n, ird_n;
      logic [31:0] d_s, d_n;
      iv_s = ($urandom_range(0, 9) < 7);
      or_s = ($urandom_range(0, 9) < 6);
      fl_s = ($urandom_range(0, 63) == 0);
      d_s  = $urandom;
      iv_n = ($urandom_range(0, 9) < 7);
      or_n = ($urandom_range(0, 9) < 6);
      fl_n = ($urandom_range(0, 63) == 0);
      d_n  = $urandom;
      up_s.valid = iv_s; up_s.data = d_s; dn_s.ready = or_s; flush_s = fl_s;
      up_n.valid = iv_n; up_n.data = d_n; dn_n.ready = or_n; flush_n = fl_n;
      #1;
      ird_s = (q_s.size() < 2) && !fl_s;
      ird_n = ((q_n.size() == 0) || or_n) && !fl_n;
      chk("rnd skid in_ready", {31'd0, up_s.ready}, {31'd0, ird_s});
      chk("rnd skid out_valid", {31'd0, dn_s.valid}, {31'd0, q_s.size() != 0});
      chk("rnd skid out_data", dn_s.data, (q_s.size() != 0) ? q_s[0] : BUB);
      chk("rnd skid stall_cnt", {28'd0, stall_s}, cnt_s);
      chk("rnd noskid in_ready", {31'd0, up_n.ready}, {31'd0, ird_n});
      chk("rnd noskid out_valid", {31'd0, dn_n.valid}, {31'd0, q_n.size() != 0});
      chk("rnd noskid out_data", dn_n.data, (q_n.size() != 0) ? q_n[0] : BUB);
      chk("rnd noskid stall_cnt", {16'd0, stall_n}, cnt_n);
      if (fails > 20) begin
        $display("FAIL random: too many errors, stopping at cycle %0d", cyc);
        break;
      end

      if ((q_s.size() != 0) && !or_s && (cnt_s < 15)) cnt_s++;
      if ((q_n.size() != 0) && !or_n && (cnt_n < 65535)) cnt_n++;
      if (fl_s) begin
        q_s.delete();
      end else begin
        if ((q_s.size() != 0) && or_s) void'(q_s.pop_front());
        if (iv_s && ird_s) q_s.push_back(d_s);
      end
      if (fl_n) begin
        q_n.delete();
      end else begin
        if ((q_n.size() != 0) && or_n) void'(q_n.pop_front());
        if (iv_n && ird_n) q_n.push_back(d_n);
      end
      @(negedge clk);
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
